// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed seven-segment scan controller.
// Scans NUM_DIGITS digits from a flat pattern bus and adds per-digit blanking,
// frame-latched (tear-free) data, anti-ghost dead time, PWM dimming, an enable
// and a frame-start strobe.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           scan enable; low clears the scan and darkens the display
//   digits       NUM_DIGITS*SEG_W segment patterns (active-low bits),
//                digit i = digits[i*SEG_W +: SEG_W]
//   blank_mask   1 = digit i forced dark
//   brightness   PWM duty code, all ones = maximum
//   sseg         registered segment drive
//   an           registered one-hot (one-cold if ACTIVE_LOW) anode drive
//   frame_start  one-cycle pulse on the first output cycle of digit 0
//
// Optional feature: define SSEG_SCAN_DIM_EN to include the PWM brightness
// term in the drive condition. Without it brightness is ignored and each slot
// is lit for its full length minus the dead time.

module sseg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SEG_W      = 8,
    parameter int PRESCALE_W = 16,
    parameter int BRIGHT_W   = 4,
    parameter int DEAD       = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
    input  logic [BRIGHT_W-1:0]         brightness,
    output logic [SEG_W-1:0]            sseg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [PRESCALE_W-1:0] Q_MAX   = '1;
    localparam logic [PRESCALE_W-1:0] DEAD_Q  = PRESCALE_W'(DEAD);
    localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // Inactive levels of the pins
    localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

    // Patterns are active-low; flip them for an active-high board
    localparam logic [SEG_W-1:0]      SEG_FLIP = {SEG_W{~ACTIVE_LOW}};

    localparam logic [NUM_DIGITS-1:0] AN_ONE =
        {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0]       q_q, q_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        load_pend_q, load_pend_d;
    logic                        last_q, last_d;
    logic [NUM_DIGITS*SEG_W-1:0] shadow_digits_q, shadow_digits_d;
    logic [NUM_DIGITS-1:0]       shadow_blank_q, shadow_blank_d;
    logic [SEG_W-1:0]            sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic                        frame_start_q, frame_start_d;

    logic                        frame_top;
    logic                        pwm_ok;
    logic                        on;
    logic [SEG_W-1:0]            cur_pat;

    assign frame_top = (q_q == '0) && (idx_q == '0);

`ifdef SSEG_SCAN_DIM_EN
    // Coarse slot phase against the duty code gives the PWM window
    assign pwm_ok = q_q[PRESCALE_W-1 -: BRIGHT_W] <= brightness;
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign pwm_ok = 1'b1;
`endif

    always_comb begin
        q_d             = q_q;
        idx_d           = idx_q;
        load_pend_d     = load_pend_q;
        last_d          = 1'b0;
        shadow_digits_d = shadow_digits_q;
        shadow_blank_d  = shadow_blank_q;
        an_d            = AN_OFF;
        sseg_d          = SEG_OFF;
        frame_start_d   = 1'b0;
        on              = 1'b0;
        cur_pat         = '0;

        if (!en) begin
            q_d         = '0;
            idx_d       = '0;
            load_pend_d = 1'b1;
        end else begin
            // Latch a whole frame at its first cycle so mid-frame input
            // changes never tear the displayed image
            if (frame_top && (load_pend_q || last_q)) begin
                shadow_digits_d = digits;
                shadow_blank_d  = blank_mask;
                load_pend_d     = 1'b0;
            end

            q_d = q_q + 1'b1;
            if (q_q == Q_MAX) begin
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end

            last_d        = (q_q == Q_MAX) && (idx_q == IDX_MAX);
            frame_start_d = frame_top;

            // Drive from the values being latched so a fresh frame is
            // visible from its very first cycle even with no dead time
            cur_pat = shadow_digits_d[idx_q*SEG_W +: SEG_W];
            on      = (q_q >= DEAD_Q) && pwm_ok && !shadow_blank_d[idx_q];

            if (on) begin
                an_d   = (AN_ONE << idx_q) ^ AN_OFF;
                sseg_d = cur_pat ^ SEG_FLIP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q             <= '0;
            idx_q           <= '0;
            load_pend_q     <= 1'b1;
            last_q          <= 1'b0;
            shadow_digits_q <= '0;
            shadow_blank_q  <= '0;
            an_q            <= AN_OFF;
            sseg_q          <= SEG_OFF;
            frame_start_q   <= 1'b0;
        end else begin
            q_q             <= q_d;
            idx_q           <= idx_d;
            load_pend_q     <= load_pend_d;
            last_q          <= last_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_blank_q  <= shadow_blank_d;
            an_q            <= an_d;
            sseg_q          <= sseg_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign sseg        = sseg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: scoreboard bench for sseg_scan_ctrl.
// A cycle model pushes expected outputs; they are popped after each edge.

module tb_sseg_scan_ctrl;

    localparam int ND = 4;
    localparam int SW = 8;
    localparam int PW = 4;
    localparam int BW = 2;
    localparam int DEAD = 1;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [ND*SW-1:0] digits;
    logic [ND-1:0] blank_mask;
    logic [BW-1:0] brightness;
    logic [SW-1:0] sseg;
    logic [ND-1:0] an;
    logic frame_start;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .SEG_W(SW),
        .PRESCALE_W(PW),
        .BRIGHT_W(BW),
        .DEAD(DEAD),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .digits(digits),
        .blank_mask(blank_mask),
        .brightness(brightness),
        .sseg(sseg),
        .an(an),
        .frame_start(frame_start)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [ND-1:0] an;
        logic [SW-1:0] sseg;
        logic fs;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [PW-1:0] m_q;
    logic [1:0] m_idx;
    logic [ND*SW-1:0] m_dig;
    logic [ND-1:0] m_blank;
    bit m_pend, m_last;

    // Observation counters for directed checks
    int act_cnt, fs_cnt, d2_cnt, match_cnt;
    logic [ND-1:0] match_an;
    logic [SW-1:0] match_seg;

    task automatic step();
        exp_t e, o;
        bit on;
        @(posedge clk);
        e = '{an: '1, sseg: '1, fs: 1'b0};
        if (rst) begin
            m_q = '0; m_idx = '0; m_dig = '0; m_blank = '0;
            m_pend = 1; m_last = 0;
        end else if (!en) begin
            m_q = '0; m_idx = '0; m_pend = 1; m_last = 0;
        end else begin
            if (m_q == 0 && m_idx == 0 && (m_pend || m_last)) begin
                m_dig = digits;
                m_blank = blank_mask;
                m_pend = 0;
            end
            on = (m_q >= DEAD) && !m_blank[m_idx];
`ifdef SSEG_SCAN_DIM_EN
            on = on && (m_q[PW-1 -: BW] <= brightness);
`endif
            if (on) begin
                e.an = ~(4'b0001 << m_idx);
                e.sseg = m_dig[m_idx*SW +: SW];
            end
            e.fs = (m_q == 0 && m_idx == 0);
            m_last = (m_q == 4'hF && m_idx == 2'd3);
            if (m_q == 4'hF) m_idx = m_idx + 1'b1;
            m_q = m_q + 1'b1;
        end
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        chk("an", 32'(an), 32'(o.an));
        chk("sseg", 32'(sseg), 32'(o.sseg));
        chk("frame_start", 32'(frame_start), 32'(o.fs));
        chk("onecold", 32'($countones(~an) <= 1), 32'd1);
        if (an != 4'hF) act_cnt++;
        if (frame_start) fs_cnt++;
        if (an == 4'b1011) d2_cnt++;
        if (an == match_an && sseg == match_seg) match_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step();
        end
    endtask

    task automatic clr();
        act_cnt = 0; fs_cnt = 0; d2_cnt = 0; match_cnt = 0;
    endtask

    int exp_b1, exp_b0, exp_full;

    initial begin
`ifdef SSEG_SCAN_DIM_EN
        exp_b1 = 28; exp_b0 = 12;
`else
        exp_b1 = 60; exp_b0 = 60;
`endif
        exp_full = 60;
        match_an = 4'b1110; match_seg = 8'hC0;
        m_q = '0; m_idx = '0; m_dig = '0; m_blank = '0;
        m_pend = 1; m_last = 0;
        rst = 1; en = 0; brightness = 2'd3; blank_mask = '0;
        digits = {8'hA4, 8'hB0, 8'h99, 8'hC0};
        run(2);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sseg", 32'(sseg), 32'hFF);
        chk("rst_fs", 32'(frame_start), 32'd0);

        rst = 0; en = 1;
        clr(); run(64);
        chk("full_active", act_cnt, exp_full);
        chk("full_fs", fs_cnt, 1);
        chk("d0_pattern", match_cnt, 15);
        clr(); run(64);
        chk("fs_period", fs_cnt, 1);

        brightness = 2'd1;
        clr(); run(64);
        chk("b1_active", act_cnt, exp_b1);
        brightness = 2'd0;
        clr(); run(64);
        chk("b0_active", act_cnt, exp_b0);

        brightness = 2'd3; blank_mask = 4'b0100;
        clr(); run(64);
        chk("blank_d2", d2_cnt, 0);
        chk("blank_active", act_cnt, 45);

        blank_mask = '0;
        run(40);
        digits[15:8] = 8'h00;
        match_an = 4'b1101; match_seg = 8'h99;
        clr(); run(24);
        chk("stale_d1", match_cnt, 0);
        match_seg = 8'h00;
        clr(); run(64);
        chk("new_d1", match_cnt, 15);

        run(36);
        digits[7:0] = 8'h88;
        en = 0;
        run(3);
        chk("en_off_an", 32'(an), 32'hF);
        en = 1;
        match_an = 4'b1110; match_seg = 8'h88;
        clr(); run(64);
        chk("reen_d0", match_cnt, 15);
        chk("reen_fs", fs_cnt, 1);

        run(20);
        rst = 1;
        run(1);
        chk("rst_mid_an", 32'(an), 32'hF);
        rst = 0;
        clr(); run(64);
        chk("rst_restart_fs", fs_cnt, 1);
        chk("rst_restart_d0", match_cnt, 15);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
